bram_copy_ctrl: RTL and testbench

//  Word-copy engine placed between two my_bram instances: drives the source BRAM read port,

---
 rtl/bram_copy_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_bram_copy_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram_copy_ctrl.sv
// -----------------------------------------------------------------------------
// bram_copy_ctrl
//   Word-copy engine placed between two BRAM instances. It issues sequential
//   reads on the source port, carries each word's destination address and valid
//   bit through a pipeline as deep as the source read latency, and writes the
//   returning data to the destination port one word per cycle. A one-cycle
//   start request begins a copy; a one-cycle done pulse ends it.
//
// Optional feature macro: COPY_CHECKSUM_EN
//   When defined, adds output checksum[31:0]: cleared on an accepted start, sums
//   every written word (mod 2^32), holds its final value from done until the
//   next accepted start.
//
// Ports
//   BRAM_CLK    in   clock, rising edge
//   BRAM_RST    in   asynchronous active-low reset
//   start       in   one-cycle copy request, only honoured in IDLE
//   src_base    in   source start byte address
//   dst_base    in   destination start byte address
//   len         in   number of 32-bit words to copy (0 allowed)
//   SRC_ADDR    out  source read byte address
//   SRC_EN      out  source enable, high on issue cycles
//   SRC_RDDATA  in   source read data, valid RD_LATENCY cycles after address
//   DST_ADDR    out  destination write byte address
//   DST_WRDATA  out  destination write data (SRC_RDDATA passed straight through)
//   DST_EN      out  destination enable
//   DST_WE      out  destination byte write enables
//   busy        out  copy in progress (through the done cycle)
//   done        out  one-cycle completion pulse
//   checksum    out  (COPY_CHECKSUM_EN only) running sum of written words
// -----------------------------------------------------------------------------
module bram_copy_ctrl #(
    parameter int BRAM_ADDR_WIDTH = 15,
    parameter int RD_LATENCY      = 2,
    parameter int ADDR_STEP       = 4
) (
    input  logic                         BRAM_CLK,
    input  logic                         BRAM_RST,
    input  logic                         start,
    input  logic [BRAM_ADDR_WIDTH-1:0]   src_base,
    input  logic [BRAM_ADDR_WIDTH-1:0]   dst_base,
    input  logic [BRAM_ADDR_WIDTH-2:0]   len,
    output logic [BRAM_ADDR_WIDTH-1:0]   SRC_ADDR,
    output logic                         SRC_EN,
    input  logic [31:0]                  SRC_RDDATA,
    output logic [BRAM_ADDR_WIDTH-1:0]   DST_ADDR,
    output logic [31:0]                  DST_WRDATA,
    output logic                         DST_EN,
    output logic [3:0]                   DST_WE,
    output logic                         busy,
`ifdef COPY_CHECKSUM_EN
    output logic [31:0]                  checksum,
`endif
    output logic                         done
);

    localparam int AW = BRAM_ADDR_WIDTH;
    localparam int CW = BRAM_ADDR_WIDTH - 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [AW-1:0] STEP    = AW'(ADDR_STEP);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // Byte-address advance; wraps modulo 2^AW by construction.
    function automatic logic [AW-1:0] addr_next(input logic [AW-1:0] addr);
        return addr + STEP;
    endfunction

    logic [1:0]    r_state;
    logic [AW-1:0] r_src_addr;
    logic          r_src_en;
    logic [AW-1:0] r_dst_issue;   // destination address paired with the word being issued
    logic [CW-1:0] r_remain;      // words still to issue after the current one
    logic          r_busy;
    logic          r_done;

    logic [RD_LATENCY-1:0] r_pipe_v;
    logic [AW-1:0]         r_pipe_a [RD_LATENCY];

    logic [1:0] w_state_nxt;
    logic       w_accept;
    logic       w_pipe_early;

    // Any word still in a pipeline stage other than the last one.
    always_comb begin
        w_pipe_early = 1'b0;
        for (int i = 0; i < RD_LATENCY - 1; i++) begin
            w_pipe_early = w_pipe_early | r_pipe_v[i];
        end
    end

    // Next-state decode. DRAIN leaves once only the final stage may hold a
    // word, so done lands the cycle after the last write.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (len != '0) begin
                        w_state_nxt = S_ISSUE;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (r_remain == '0) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_DRAIN: begin
                if (!w_pipe_early) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Control state, issue address/counter and registered status outputs.
    always_ff @(posedge BRAM_CLK or negedge BRAM_RST) begin
        if (!BRAM_RST) begin
            r_state     <= S_IDLE;
            r_src_addr  <= '0;
            r_src_en    <= 1'b0;
            r_dst_issue <= '0;
            r_remain    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_src_en <= (w_state_nxt == S_ISSUE);
            r_busy   <= (w_state_nxt != S_IDLE);
            r_done   <= (w_state_nxt == S_DONE);
            if (w_accept) begin
                r_src_addr  <= src_base;
                r_dst_issue <= dst_base;
                r_remain    <= len - CNT_ONE;
            end else if (r_state == S_ISSUE && r_remain != '0) begin
                r_src_addr  <= addr_next(r_src_addr);
                r_dst_issue <= addr_next(r_dst_issue);
                r_remain    <= r_remain - CNT_ONE;
            end else begin
                r_src_addr  <= r_src_addr;
                r_dst_issue <= r_dst_issue;
                r_remain    <= r_remain;
            end
        end
    end

    // Latency-matching pipeline: stage 0 captures the word issued this cycle,
    // the last stage lines up with its data on SRC_RDDATA.
    always_ff @(posedge BRAM_CLK or negedge BRAM_RST) begin
        if (!BRAM_RST) begin
            r_pipe_v <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_pipe_a[i] <= '0;
            end
        end else begin
            r_pipe_v[0] <= r_src_en;
            r_pipe_a[0] <= r_dst_issue;
            for (int i = RD_LATENCY - 1; i > 0; i--) begin
                r_pipe_v[i] <= r_pipe_v[i-1];
                r_pipe_a[i] <= r_pipe_a[i-1];
            end
        end
    end

`ifdef COPY_CHECKSUM_EN
    logic [31:0] r_checksum;

    // Running sum of written words, restarted by each accepted request.
    always_ff @(posedge BRAM_CLK or negedge BRAM_RST) begin
        if (!BRAM_RST) begin
            r_checksum <= 32'h0000_0000;
        end else if (w_accept) begin
            r_checksum <= 32'h0000_0000;
        end else if (r_pipe_v[RD_LATENCY-1]) begin
            r_checksum <= r_checksum + SRC_RDDATA;
        end else begin
            r_checksum <= r_checksum;
        end
    end

    assign checksum = r_checksum;
`endif

    assign SRC_ADDR   = r_src_addr;
    assign SRC_EN     = r_src_en;
    assign DST_ADDR   = r_pipe_a[RD_LATENCY-1];
    assign DST_EN     = r_pipe_v[RD_LATENCY-1];
    assign DST_WE     = r_pipe_v[RD_LATENCY-1] ? 4'hF : 4'h0;
    assign DST_WRDATA = SRC_RDDATA;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_bram_copy_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bram_copy_ctrl
//   Directed bench for bram_copy_ctrl with behavioural source/destination BRAMs
//   (source read latency 2). Each copy is checked cycle by cycle against the
//   expected issue/write/busy/done timeline, then destination contents and the
//   number of writes are checked.
// -----------------------------------------------------------------------------
module tb_bram_copy_ctrl;

    localparam int RDL = 2;

    logic        BRAM_CLK;
    logic        BRAM_RST;
    logic        start;
    logic [14:0] src_base;
    logic [14:0] dst_base;
    logic [13:0] len;
    logic [14:0] SRC_ADDR;
    logic        SRC_EN;
    logic [31:0] SRC_RDDATA;
    logic [14:0] DST_ADDR;
    logic [31:0] DST_WRDATA;
    logic        DST_EN;
    logic [3:0]  DST_WE;
    logic        busy;
    logic        done;
`ifdef COPY_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int total_cnt = 0;
    int bad_cnt   = 0;
    int wr_cnt    = 0;

    logic [31:0] src_mem [8192];
    logic [31:0] dst_mem [8192];
    logic [31:0] rd_s1;
    logic [31:0] rd_s2;

    bram_copy_ctrl #(
        .BRAM_ADDR_WIDTH (15),
        .RD_LATENCY      (RDL),
        .ADDR_STEP       (4)
    ) dut (
        .BRAM_CLK   (BRAM_CLK),
        .BRAM_RST   (BRAM_RST),
        .start      (start),
        .src_base   (src_base),
        .dst_base   (dst_base),
        .len        (len),
        .SRC_ADDR   (SRC_ADDR),
        .SRC_EN     (SRC_EN),
        .SRC_RDDATA (SRC_RDDATA),
        .DST_ADDR   (DST_ADDR),
        .DST_WRDATA (DST_WRDATA),
        .DST_EN     (DST_EN),
        .DST_WE     (DST_WE),
        .busy       (busy),
`ifdef COPY_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .done       (done)
    );

    initial BRAM_CLK = 1'b0;
    always #5 BRAM_CLK = ~BRAM_CLK;

    // Source BRAM: two-cycle registered read.
    always @(posedge BRAM_CLK) begin
        if (SRC_EN) rd_s1 <= src_mem[SRC_ADDR[14:2]];
        rd_s2 <= rd_s1;
    end
    assign SRC_RDDATA = rd_s2;

    // Destination BRAM write port plus write counter.
    always @(posedge BRAM_CLK) begin
        if (DST_EN && DST_WE == 4'hF) begin
            dst_mem[DST_ADDR[14:2]] <= DST_WRDATA;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        if (got !== exp) begin
            bad_cnt = bad_cnt + 1;
            $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One copy, checked cycle by cycle. Cycle 0 is the accepting edge.
    task automatic run_copy(input logic [14:0] sb, input logic [14:0] db, input logic [13:0] ln,
                            input int repulse_at, input int rst_at, input logic [31:0] exp_sum);
        int          done_cyc;
        int          n_cyc;
        logic        in_rst;
        logic        e_src;
        logic        e_dst;
        logic [14:0] e_addr;
        done_cyc = (ln == 14'd0) ? 1 : int'(ln) + RDL + 1;
        n_cyc    = done_cyc + 2;
        @(negedge BRAM_CLK);
        src_base = sb;
        dst_base = db;
        len      = ln;
        start    = 1'b1;
        for (int n = 1; n <= n_cyc; n++) begin
            @(negedge BRAM_CLK);
            start = 1'b0;
            if (n == 1) begin
                // Inputs change after acceptance; the copy must not follow them.
                src_base = sb ^ 15'h0040;
                dst_base = db ^ 15'h0040;
                len      = ln + 14'd3;
            end
            if (rst_at != 0 && n == rst_at) begin
                BRAM_RST = 1'b0;
                #1;
            end
            in_rst = (rst_at != 0) && (n >= rst_at);
            e_src  = !in_rst && (n <= int'(ln));
            e_dst  = !in_rst && (n >= 1 + RDL) && (n <= int'(ln) + RDL);
            check_val("src_en", {31'd0, SRC_EN}, {31'd0, e_src});
            if (e_src) begin
                e_addr = sb + 15'((n - 1) * 4);
                check_val("src_addr", {17'd0, SRC_ADDR}, {17'd0, e_addr});
            end
            check_val("dst_en", {31'd0, DST_EN}, {31'd0, e_dst});
            check_val("dst_we", {28'd0, DST_WE}, {28'd0, {4{e_dst}}});
            if (e_dst) begin
                e_addr = db + 15'((n - 1 - RDL) * 4);
                check_val("dst_addr", {17'd0, DST_ADDR}, {17'd0, e_addr});
            end
            check_val("busy", {31'd0, busy}, {31'd0, (!in_rst && n <= done_cyc)});
            check_val("done", {31'd0, done}, {31'd0, (!in_rst && n == done_cyc)});
`ifdef COPY_CHECKSUM_EN
            if (!in_rst && n == done_cyc) check_val("checksum", checksum, exp_sum);
            if (in_rst) check_val("checksum_rst", checksum, 32'h0000_0000);
`endif
            if (n == repulse_at) start = 1'b1;
        end
        if (rst_at != 0) begin
            @(negedge BRAM_CLK);
            BRAM_RST = 1'b1;
        end
    endtask

    int wr0;

    initial begin
        BRAM_RST = 1'b0;
        start    = 1'b0;
        src_base = 15'd0;
        dst_base = 15'd0;
        len      = 14'd0;
        rd_s1    = 32'd0;
        rd_s2    = 32'd0;
        for (int i = 0; i < 8192; i++) begin
            src_mem[i] = 32'h0000_0000;
            dst_mem[i] = 32'h0000_0000;
        end
        for (int k = 0; k < 8; k++) src_mem[k] = 32'h0000_1000 + 32'(k);
        src_mem[13'h1FFE] = 32'hCAFE_0001;
        src_mem[13'h1FFF] = 32'hCAFE_0002;

        // Reset state
        repeat (3) @(negedge BRAM_CLK);
        check_val("rst_src_en", {31'd0, SRC_EN}, 32'd0);
        check_val("rst_dst_en", {31'd0, DST_EN}, 32'd0);
        check_val("rst_dst_we", {28'd0, DST_WE}, 32'd0);
        check_val("rst_busy",   {31'd0, busy},   32'd0);
        check_val("rst_done",   {31'd0, done},   32'd0);
`ifdef COPY_CHECKSUM_EN
        check_val("rst_checksum", checksum, 32'h0000_0000);
`endif
        BRAM_RST = 1'b1;
        repeat (2) @(negedge BRAM_CLK);

        // 1: eight-word copy
        wr0 = wr_cnt;
        run_copy(15'h0000, 15'h0000, 14'd8, 0, 0, 32'h0000_801C);
        check_val("c1_writes", 32'(wr_cnt - wr0), 32'd8);
        for (int k = 0; k < 8; k++) check_val("c1_dst_mem", dst_mem[k], 32'h0000_1000 + 32'(k));

        // 2: zero-length copy
        wr0 = wr_cnt;
        run_copy(15'h0000, 15'h0200, 14'd0, 0, 0, 32'h0000_0000);
        check_val("c2_writes", 32'(wr_cnt - wr0), 32'd0);

        // 3: source address wrap
        wr0 = wr_cnt;
        run_copy(15'h7FF8, 15'h0100, 14'd4, 0, 0, 32'h95FC_2004);
        check_val("c3_writes", 32'(wr_cnt - wr0), 32'd4);
        check_val("c3_dst0", dst_mem[64], 32'hCAFE_0001);
        check_val("c3_dst1", dst_mem[65], 32'hCAFE_0002);
        check_val("c3_dst2", dst_mem[66], 32'h0000_1000);
        check_val("c3_dst3", dst_mem[67], 32'h0000_1001);

        // 4: start re-pulsed mid-copy is ignored
        wr0 = wr_cnt;
        run_copy(15'h0000, 15'h0400, 14'd8, 4, 0, 32'h0000_801C);
        repeat (4) @(negedge BRAM_CLK);
        check_val("c4_writes", 32'(wr_cnt - wr0), 32'd8);
        check_val("c4_busy_after", {31'd0, busy}, 32'd0);
        for (int k = 0; k < 8; k++) check_val("c4_dst_mem", dst_mem[256 + k], 32'h0000_1000 + 32'(k));

        // 5: reset mid-copy, then a fresh copy
        wr0 = wr_cnt;
        run_copy(15'h0000, 15'h0600, 14'd8, 0, 5, 32'h0000_0000);
        repeat (3) @(negedge BRAM_CLK);
        check_val("c5_writes", 32'(wr_cnt - wr0), 32'd2);
        check_val("c5_dst_word2", dst_mem[384 + 2], 32'h0000_0000);
        wr0 = wr_cnt;
        run_copy(15'h0000, 15'h0800, 14'd8, 0, 0, 32'h0000_801C);
        check_val("c5b_writes", 32'(wr_cnt - wr0), 32'd8);
        for (int k = 0; k < 8; k++) check_val("c5b_dst_mem", dst_mem[512 + k], 32'h0000_1000 + 32'(k));

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
